// File: rtl/riscv_lsu_bus_if.sv
// Data-bus bundle between the M-stage LSU (master) and the memory port (slave).
// Single outstanding req/gnt/rvalid transaction.
interface riscv_lsu_bus_if;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_gnt;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;

    modport master (
        output o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata,
        input  i_bus_gnt, i_bus_rvalid, i_bus_rdata
    );
    modport slave (
        input  o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata,
        output i_bus_gnt, i_bus_rvalid, i_bus_rdata
    );
endinterface

// File: rtl/riscv_lsu_bus.sv
// M-stage load/store unit: one outstanding req/gnt/rvalid access, byte lane alignment,
// load extension. Optional bus watchdog enabled by defining RISCV_BUS_TIMEOUT_EN.
module riscv_lsu_bus #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_mem_req,
    input  logic        i_mem_we,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [2:0]  i_mem_funct3,
    output logic        o_bus_stallM,
    output logic [31:0] o_rdataM,
    output logic        o_rdata_valid,
    output logic        o_misalign,
    output logic        o_bus_err,
    riscv_lsu_bus_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      state;
    logic        req_q, we_q, rvld_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;

    logic        aligned, start, tmo;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    function automatic logic [31:0] extract(logic [31:0] w, logic [1:0] off, logic [2:0] f3);
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (f3[1:0])
            2'b00:   return {{24{~f3[2] & sh[7]}},  sh[7:0]};
            2'b01:   return {{16{~f3[2] & sh[15]}}, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // funct3[1:0] selects size; 011/110/111 fall into the word case.
    always_comb begin
        aligned = !(((i_mem_funct3[1:0] == 2'b01) && i_mem_addr[0]) ||
                    (i_mem_funct3[1] && (i_mem_addr[1:0] != 2'b00)));
        case (i_mem_funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << i_mem_addr[1:0];
                wdata_c = {4{i_mem_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << i_mem_addr[1:0];
                wdata_c = {2{i_mem_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = i_mem_wdata;
            end
        endcase
    end

    assign start        = rst_n && (state == IDLE) && i_mem_req;
    assign o_misalign   = start && !aligned;
    assign o_bus_stallM = rst_n && ((start && aligned) || (state == REQ) || (state == RESP));

`ifdef RISCV_BUS_TIMEOUT_EN
    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);
    logic [7:0] tcnt;
    logic       err_q;

    // Fires on the cycle whose increment would make the count reach the limit.
    assign tmo = ((state == REQ) || (state == RESP)) && ((tcnt + 8'd1) == TMO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt  <= 8'd0;
            err_q <= 1'b0;
        end else begin
            err_q <= tmo;
            if (state == IDLE)
                tcnt <= 8'd0;
            else if ((state == REQ) || (state == RESP))
                tcnt <= tcnt + 8'd1;
        end
    end
    assign o_bus_err = err_q;
`else
    assign tmo       = 1'b0;
    assign o_bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            rvld_q  <= 1'b0;
        end else begin
            rvld_q <= 1'b0;
            case (state)
                IDLE: if (i_mem_req && aligned) begin
                    state   <= REQ;
                    req_q   <= 1'b1;
                    we_q    <= i_mem_we;
                    addr_q  <= {i_mem_addr[31:2], 2'b00};
                    be_q    <= be_c;
                    wdata_q <= wdata_c;
                    off_q   <= i_mem_addr[1:0];
                    f3_q    <= i_mem_funct3;
                end
                REQ: if (tmo) begin
                    state <= DONE;
                    req_q <= 1'b0;
                    if (!we_q) begin
                        rdata_q <= 32'd0;
                        rvld_q  <= 1'b1;
                    end
                end else if (bus.i_bus_gnt) begin
                    req_q <= 1'b0;
                    state <= we_q ? DONE : RESP;
                end
                RESP: if (tmo) begin
                    state   <= DONE;
                    rdata_q <= 32'd0;
                    rvld_q  <= 1'b1;
                end else if (bus.i_bus_rvalid) begin
                    state   <= DONE;
                    rdata_q <= extract(bus.i_bus_rdata, off_q, f3_q);
                    rvld_q  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_bus_req   = req_q;
    assign bus.o_bus_we    = we_q;
    assign bus.o_bus_addr  = addr_q;
    assign bus.o_bus_be    = be_q;
    assign bus.o_bus_wdata = wdata_q;
    assign o_rdataM        = rdata_q;
    assign o_rdata_valid   = rvld_q;
endmodule

// File: tb/tb_riscv_lsu_bus.sv
// Randomized + directed bench for riscv_lsu_bus against a byte-level access model.
module tb_riscv_lsu_bus;
`ifdef RISCV_BUS_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_mem_req, i_mem_we;
    logic [31:0] i_mem_addr, i_mem_wdata;
    logic [2:0]  i_mem_funct3;
    logic        o_bus_stallM, o_rdata_valid, o_misalign, o_bus_err;
    logic [31:0] o_rdataM;
    int          checks = 0;
    int          errors = 0;

    riscv_lsu_bus_if bus ();

    riscv_lsu_bus #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr),
        .i_mem_wdata(i_mem_wdata), .i_mem_funct3(i_mem_funct3),
        .o_bus_stallM(o_bus_stallM), .o_rdataM(o_rdataM), .o_rdata_valid(o_rdata_valid),
        .o_misalign(o_misalign), .o_bus_err(o_bus_err), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: access size in bytes, byte mask, replicated store word, extended load.
    function automatic int size_of(logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(logic [31:0] addr, logic [2:0] f3);
        logic [3:0] m = '0;
        int o = int'(addr % 4);
        for (int i = 0; i < 4; i++)
            m[i] = (size_of(f3) == 4) || (i >= o && i < o + size_of(f3));
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(logic [31:0] wd, logic [2:0] f3);
        if (size_of(f3) == 1) return (wd % 256) * 32'h0101_0101;
        if (size_of(f3) == 2) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] word, logic [31:0] addr, logic [2:0] f3);
        logic [31:0] v;
        int sz = size_of(f3);
        bit sgn = (f3 == 3'd0 || f3 == 3'd1);
        if (sz == 4) return word;
        v = (word / (32'd1 << (8 * (addr % 4)))) % (32'd1 << (8 * sz));
        if (sgn && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
        return v;
    endfunction

    function automatic bit model_aligned(logic [31:0] addr, logic [2:0] f3);
        return (addr % size_of(f3)) == 0;
    endfunction

    // Runs one access through the DUT with a reactive bus: gnt after gd waiting REQ
    // cycles, rvalid after rd waiting RESP cycles. Returns after the no-stall cycle.
    task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] word, input logic [2:0] f3,
                             input int gd, input int rd, input string name);
        bit al = model_aligned(addr, f3);
        int exp_stall = al ? (1 + gd + 1 + (we ? 0 : rd + 1)) : 0;
        int stall_n = 0, req_n = 0, mis_n = 0, rv_n = 0, resp_w = 0;
        bit gave_gnt = 0, in_resp = 0, done = 0;
        logic [31:0] got = '0;
        @(posedge clk); #1;
        i_mem_req = 1'b1; i_mem_we = we; i_mem_addr = addr;
        i_mem_wdata = wd; i_mem_funct3 = f3;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            if (gave_gnt) begin gave_gnt = 0; in_resp = !we; end
            if (o_bus_stallM) stall_n++;
            if (o_misalign)   mis_n++;
            if (o_rdata_valid) begin rv_n++; got = o_rdataM; end
            bus.i_bus_gnt = 1'b0;
            if (bus.o_bus_req) begin
                req_n++;
                checks++;
                if (bus.o_bus_addr !== {addr[31:2], 2'b00} || bus.o_bus_be !== model_be(addr, f3) ||
                    bus.o_bus_we !== we || (we && bus.o_bus_wdata !== model_wdata(wd, f3))) begin
                    errors++;
                    $display("FAIL %s bus fields: addr=%h be=%b we=%b wdata=%h, required addr=%h be=%b we=%b wdata=%h",
                             name, bus.o_bus_addr, bus.o_bus_be, bus.o_bus_we, bus.o_bus_wdata,
                             {addr[31:2], 2'b00}, model_be(addr, f3), we, model_wdata(wd, f3));
                end
                if (req_n > gd) begin bus.i_bus_gnt = 1'b1; gave_gnt = 1; end
            end
            bus.i_bus_rvalid = 1'b0;
            bus.i_bus_rdata  = $urandom;
            if (in_resp) begin
                resp_w++;
                if (resp_w > rd) begin
                    bus.i_bus_rvalid = 1'b1; bus.i_bus_rdata = word; in_resp = 0;
                end
            end
            if (!o_bus_stallM) done = 1;
        end
        i_mem_req = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: access still stalling after 64 cycles, required completion", name);
        end
        checks++;
        if (stall_n != exp_stall) begin
            errors++;
            $display("FAIL %s stall cycles: got %0d, required %0d", name, stall_n, exp_stall);
        end
        checks++;
        if (mis_n != (al ? 0 : 1) || (!al && req_n != 0)) begin
            errors++;
            $display("FAIL %s misalign: pulses %0d req cycles %0d, required pulses %0d", name, mis_n, req_n, al ? 0 : 1);
        end
        checks++;
        if (rv_n != ((al && !we) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s rdata_valid pulses: got %0d, required %0d", name, rv_n, (al && !we) ? 1 : 0);
        end
        if (al && !we) begin
            checks++;
            if (got !== model_load(word, addr, f3)) begin
                errors++;
                $display("FAIL %s load data: got %h, required %h", name, got, model_load(word, addr, f3));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 32'h105;
        i_mem_wdata = $urandom; i_mem_funct3 = 3'b010;
        bus.i_bus_gnt = 1'b1; bus.i_bus_rvalid = 1'b1; bus.i_bus_rdata = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.o_bus_req !== 1'b0 || bus.o_bus_we !== 1'b0 || bus.o_bus_be !== 4'd0 ||
            bus.o_bus_addr !== 32'd0 || bus.o_bus_wdata !== 32'd0 || o_rdataM !== 32'd0) begin
            errors++;
            $display("FAIL reset regs: req=%b we=%b be=%b addr=%h wdata=%h rdata=%h, required all 0",
                     bus.o_bus_req, bus.o_bus_we, bus.o_bus_be, bus.o_bus_addr, bus.o_bus_wdata, o_rdataM);
        end
        checks++;
        if (o_bus_stallM !== 1'b0 || o_misalign !== 1'b0 || o_rdata_valid !== 1'b0 || o_bus_err !== 1'b0) begin
            errors++;
            $display("FAIL reset pulses: stall=%b mis=%b rv=%b err=%b, required 0",
                     o_bus_stallM, o_misalign, o_rdata_valid, o_bus_err);
        end
        i_mem_req = 1'b0; bus.i_bus_gnt = 1'b0; bus.i_bus_rvalid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        do_access(1'b0, 32'h103, 32'h0, 32'h80FF_1234, 3'b000, 0, 0, "lb_0x103");
        do_access(1'b1, 32'h202, 32'h0000_ABCD, 32'h0, 3'b001, 2, 0, "sh_0x202");
        do_access(1'b0, 32'h105, 32'h0, 32'h0, 3'b010, 0, 0, "lw_misaligned");
        do_access(1'b0, 32'h0F3, 32'h0, 32'h0, 3'b001, 0, 0, "lh_misaligned");
    endtask

    task automatic test_back_to_back();
        do_access(1'b0, 32'h002, 32'h0, 32'h1234_5678, 3'b101, 0, 0, "b2b_lhu");
        do_access(1'b1, 32'h001, 32'h0000_00A5, 32'h0, 3'b000, 0, 0, "b2b_sb");
        do_access(1'b0, 32'h7FC, 32'h0, 32'hDEAD_BEEF, 3'b110, 1, 2, "b2b_f3_110");
    endtask

    task automatic test_random();
        logic [2:0] ld_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        logic [2:0] st_f3 [3] = '{3'd0, 3'd1, 3'd2};
        for (int n = 0; n < 40; n++) begin
            bit we = 1'($urandom_range(0, 1));
            logic [2:0] f3 = we ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 7)];
            do_access(we, $urandom, $urandom, $urandom, f3,
                      $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        @(posedge clk); #1;
        i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 32'h40; i_mem_funct3 = 3'b010;
        for (int cyc = 0; cyc < 8 && !hit; cyc++) begin
            @(negedge clk);
            bus.i_bus_gnt = bus.o_bus_req;
            if (bus.o_bus_req) hit = 1;
        end
        @(negedge clk);
        bus.i_bus_gnt = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_bus_req !== 1'b0 || o_rdataM !== 32'd0 || o_bus_stallM !== 1'b0 || !hit) begin
            errors++;
            $display("FAIL reset_mid: req=%b rdata=%h stall=%b issued=%b, required 0/0/0 issued=1",
                     bus.o_bus_req, o_rdataM, o_bus_stallM, hit);
        end
        rst_n = 1'b1; i_mem_req = 1'b0;
        bus.i_bus_rvalid = 1'b1; bus.i_bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.i_bus_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (o_rdata_valid !== 1'b0 || o_rdataM !== 32'd0 || bus.o_bus_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid late rvalid: rv=%b rdata=%h req=%b, required 0/0/0",
                     o_rdata_valid, o_rdataM, bus.o_bus_req);
        end
    endtask

`ifdef RISCV_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int req_n = 0, err_n = 0, rv_n = 0, stall_n = 0;
        bit done = 0;
        logic [31:0] got = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        i_mem_req = 1'b1; i_mem_we = 1'b0; i_mem_addr = 32'h80; i_mem_funct3 = 3'b010;
        bus.i_bus_gnt = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(negedge clk);
            if (bus.o_bus_req) req_n++;
            if (o_bus_stallM) stall_n++;
            if (o_bus_err) err_n++;
            if (o_rdata_valid) begin rv_n++; got = o_rdataM; end
            if (!o_bus_stallM) done = 1;
        end
        i_mem_req = 1'b0;
        checks++;
        if (!done || req_n != TMO || stall_n != TMO + 1 || err_n != 1 || rv_n != 1 || got !== 32'd0) begin
            errors++;
            $display("FAIL timeout: done=%b req=%0d stall=%0d err=%0d rv=%0d rdata=%h, required 1/%0d/%0d/1/1/0",
                     done, req_n, stall_n, err_n, rv_n, got, TMO, TMO + 1);
        end
    endtask
`endif

    initial begin
        i_mem_req = 1'b0; i_mem_we = 1'b0; i_mem_addr = '0; i_mem_wdata = '0; i_mem_funct3 = '0;
        bus.i_bus_gnt = 1'b0; bus.i_bus_rvalid = 1'b0; bus.i_bus_rdata = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef RISCV_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
